l2_noc2_out_arb: RTL and testbench

//  Packet-level round-robin arbiter and output register for the L2 NoC2 output port.
//  Two requesters share the single noc2 link:
//   - pipe1 (NoC1 request pipeline)
//   - pipe2 (NoC3 response pipeline)
//  The grant is held for the whole packet, using the MSG_LENGTH field of the header flit.

---
 rtl/l2_noc2_out_arb.sv | 108 ++++++++++
 tb/tb_l2_noc2_out_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_noc2_out_arb.sv
// Packet-level round-robin arbiter between the NoC1 request pipe (pipe1) and the
// NoC3 response pipe (pipe2), feeding the registered L2 NoC2 output port.
module l2_noc2_out_arb #(
  parameter int DATA_W  = 64,
  parameter int LEN_LSB = 22,
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe1_val,
  input  logic [DATA_W-1:0] pipe1_data,
  output logic              pipe1_rdy,
  input  logic              pipe2_val,
  input  logic [DATA_W-1:0] pipe2_data,
  output logic              pipe2_rdy,
  output logic              noc2_valid_out,
  output logic [DATA_W-1:0] noc2_data_out,
  input  logic              noc2_ready_out,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt_p1,
  output logic [CNT_W-1:0]  pkt_cnt_p2
);

  typedef enum logic [1:0] {IDLE, P1_BODY, P2_BODY} state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  rem, rem_nxt;
  logic              prio, prio_nxt;   // 0 = pipe1, 1 = pipe2
  logic              sel;              // owner of the current flit, same encoding as prio
  logic              can_load;
  logic              accept;
  logic              done;
  logic [DATA_W-1:0] acc_data;
  logic [LEN_W-1:0]  hdr_len;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case/if structure can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    prio_nxt  = prio;
    done      = 1'b0;
    can_load  = !noc2_valid_out || noc2_ready_out;

    unique case (state)
      IDLE:    sel = (pipe1_val && pipe2_val) ? prio : pipe2_val;
      P1_BODY: sel = 1'b0;
      P2_BODY: sel = 1'b1;
      default: sel = 1'b0;
    endcase

    // rst_n gating keeps both requesters stalled while reset is being applied.
    pipe1_rdy = rst_n && can_load && pipe1_val && !sel;
    pipe2_rdy = rst_n && can_load && pipe2_val && sel;
    accept    = pipe1_rdy || pipe2_rdy;
    acc_data  = sel ? pipe2_data : pipe1_data;
    hdr_len   = acc_data[LEN_LSB +: LEN_W];

    if (accept) begin
      if (state == IDLE) begin
        if (hdr_len == '0) begin
          done = 1'b1;
        end else begin
          state_nxt = sel ? P2_BODY : P1_BODY;
          rem_nxt   = hdr_len;
        end
      end else begin
        rem_nxt = rem - LEN_W'(1);
        if (rem == LEN_W'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
    end

    if (done) prio_nxt = !sel;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rem            <= '0;
      prio           <= 1'b0;
      noc2_valid_out <= 1'b0;
      noc2_data_out  <= '0;
      pkt_cnt_p1     <= '0;
      pkt_cnt_p2     <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      prio  <= prio_nxt;
      if (accept) begin
        noc2_valid_out <= 1'b1;
        noc2_data_out  <= acc_data;
      end else if (noc2_ready_out) begin
        noc2_valid_out <= 1'b0;
      end
      if (done && !sel) pkt_cnt_p1 <= pkt_cnt_p1 + CNT_W'(1);
      if (done &&  sel) pkt_cnt_p2 <= pkt_cnt_p2 + CNT_W'(1);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_l2_noc2_out_arb.sv
// Directed self-checking bench for l2_noc2_out_arb: single packets, contention,
// mid-packet lockout, output stall, maximum-length packet and mid-packet reset.
module tb_l2_noc2_out_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe1_val, pipe2_val;
  logic [63:0] pipe1_data, pipe2_data;
  logic        pipe1_rdy, pipe2_rdy;
  logic        noc2_valid_out;
  logic [63:0] noc2_data_out;
  logic        noc2_ready_out;
  logic        busy;
  logic [15:0] pkt_cnt_p1, pkt_cnt_p2;

  int passed = 0;
  int total  = 0;

  l2_noc2_out_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe1_val      (pipe1_val),
    .pipe1_data     (pipe1_data),
    .pipe1_rdy      (pipe1_rdy),
    .pipe2_val      (pipe2_val),
    .pipe2_data     (pipe2_data),
    .pipe2_rdy      (pipe2_rdy),
    .noc2_valid_out (noc2_valid_out),
    .noc2_data_out  (noc2_data_out),
    .noc2_ready_out (noc2_ready_out),
    .busy           (busy),
    .pkt_cnt_p1     (pkt_cnt_p1),
    .pkt_cnt_p2     (pkt_cnt_p2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_hdr(input int len, input int id);
    mk_hdr = 64'hC0DE_0000_0000_0000 | (64'(len) << 22) | 64'(id & 'hFFFFF);
  endfunction

  function automatic logic [63:0] mk_body(input int id);
    mk_body = 64'hBEEF_0000_0000_0000 | 64'(id & 'hFFFFF);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pipe1_val = 1'b1; pipe1_data = mk_hdr(0, 1);
    pipe2_val = 1'b1; pipe2_data = mk_hdr(0, 2);
    noc2_ready_out = 1'b1;
    repeat (2) step();

    // Reset state; requesters are held off even with val high
    check("rst_p1_rdy", pipe1_rdy, 0);
    check("rst_p2_rdy", pipe2_rdy, 0);
    check("rst_valid", noc2_valid_out, 0);
    check("rst_data", noc2_data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt1", pkt_cnt_p1, 0);
    check("rst_cnt2", pkt_cnt_p2, 0);
    rst_n = 1'b1;
    pipe1_val = 1'b0;
    pipe2_val = 1'b0;

    // 1: pipe1 header L=2 plus two body flits
    pipe1_val = 1'b1; pipe1_data = mk_hdr(2, 10); #1;
    check("t1_hdr_rdy", pipe1_rdy, 1);
    step();
    check("t1_hdr_valid", noc2_valid_out, 1);
    check("t1_hdr_data", noc2_data_out, mk_hdr(2, 10));
    check("t1_busy0", busy, 1);
    pipe1_data = mk_body(11); #1;
    check("t1_b1_rdy", pipe1_rdy, 1);
    step();
    check("t1_b1_data", noc2_data_out, mk_body(11));
    check("t1_busy1", busy, 1);
    pipe1_data = mk_body(12);
    step();
    check("t1_b2_data", noc2_data_out, mk_body(12));
    check("t1_busy_end", busy, 0);
    check("t1_cnt1", pkt_cnt_p1, 1);
    pipe1_val = 1'b0;
    step();
    check("t1_valid_drop", noc2_valid_out, 0);

    // 2: header-only contention from a fresh reset (prio = pipe1)
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pipe1_val = 1'b1; pipe1_data = mk_hdr(0, 100 + i);
      pipe2_val = 1'b1; pipe2_data = mk_hdr(0, 200 + i);
      #1;
      check($sformatf("t2_p1_rdy%0d", i), pipe1_rdy, (i % 2 == 0));
      check($sformatf("t2_p2_rdy%0d", i), pipe2_rdy, (i % 2 == 1));
      step();
      check($sformatf("t2_data%0d", i), noc2_data_out,
            (i % 2 == 0) ? mk_hdr(0, 100 + i) : mk_hdr(0, 200 + i));
    end
    check("t2_cnt1", pkt_cnt_p1, 3);
    check("t2_cnt2", pkt_cnt_p2, 3);

    // 3: pipe2 locked out during pipe1's L=3 packet, then wins on prio
    pipe2_val = 1'b0;
    pipe1_data = mk_hdr(3, 300); #1;
    check("t3_hdr_rdy", pipe1_rdy, 1);
    step();
    for (int k = 1; k <= 3; k++) begin
      pipe1_data = mk_body(300 + k);
      pipe2_val = 1'b1; pipe2_data = mk_hdr(0, 400);
      #1;
      check($sformatf("t3_p1_rdy%0d", k), pipe1_rdy, 1);
      check($sformatf("t3_p2_lock%0d", k), pipe2_rdy, 0);
      step();
      check($sformatf("t3_data%0d", k), noc2_data_out, mk_body(300 + k));
    end
    check("t3_busy_end", busy, 0);
    pipe1_data = mk_hdr(0, 310); #1;
    check("t3_p2_win", pipe2_rdy, 1);
    check("t3_p1_lose", pipe1_rdy, 0);
    step();
    check("t3_p2_data", noc2_data_out, mk_hdr(0, 400));
    check("t3_cnt1", pkt_cnt_p1, 4);
    check("t3_cnt2", pkt_cnt_p2, 4);

    // 4: output stall for 5 cycles with a flit pending
    pipe2_val = 1'b0;
    pipe1_data = mk_hdr(0, 500);
    noc2_ready_out = 1'b0;
    #1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("t4_p1_stall%0d", s), pipe1_rdy, 0);
      check($sformatf("t4_p2_stall%0d", s), pipe2_rdy, 0);
      step();
      check($sformatf("t4_hold%0d", s), noc2_data_out, mk_hdr(0, 400));
      check($sformatf("t4_hold_v%0d", s), noc2_valid_out, 1);
    end
    noc2_ready_out = 1'b1; #1;
    check("t4_release_rdy", pipe1_rdy, 1);
    step();
    check("t4_release_data", noc2_data_out, mk_hdr(0, 500));
    check("t4_cnt1", pkt_cnt_p1, 5);

    // 5: maximum-length packet from pipe2, 256 flits
    pipe1_val = 1'b0;
    pipe2_val = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pipe2_data = (i == 0) ? mk_hdr(255, 600) : mk_body(600 + i);
      #1;
      check($sformatf("t5_rdy%0d", i), pipe2_rdy, 1);
      step();
      check($sformatf("t5_data%0d", i), noc2_data_out, (i == 0) ? mk_hdr(255, 600) : mk_body(600 + i));
      if (i == 254) check("t5_busy_before_last", busy, 1);
    end
    check("t5_busy_end", busy, 0);
    check("t5_cnt2", pkt_cnt_p2, 5);
    check("t5_cnt1", pkt_cnt_p1, 5);
    pipe2_val = 1'b0;
    step();
    check("t5_valid_drop", noc2_valid_out, 0);

    // 6: reset after two flits of an L=4 packet
    pipe1_val = 1'b1; pipe1_data = mk_hdr(4, 700);
    step();
    pipe1_data = mk_body(701);
    step();
    check("t6_busy_mid", busy, 1);
    rst_n = 1'b0; pipe1_data = mk_body(702); #1;
    check("t6_rst_rdy", pipe1_rdy, 0);
    step();
    check("t6_valid", noc2_valid_out, 0);
    check("t6_data", noc2_data_out, 0);
    check("t6_busy", busy, 0);
    check("t6_cnt1", pkt_cnt_p1, 0);
    check("t6_cnt2", pkt_cnt_p2, 0);
    rst_n = 1'b1;
    pipe1_data = mk_hdr(0, 800);
    pipe2_val = 1'b1; pipe2_data = mk_hdr(0, 900);
    #1;
    check("t6_p1_prio", pipe1_rdy, 1);
    check("t6_p2_wait", pipe2_rdy, 0);
    step();
    check("t6_p1_data", noc2_data_out, mk_hdr(0, 800));
    pipe1_val = 1'b0; #1;
    check("t6_p2_rdy", pipe2_rdy, 1);
    step();
    check("t6_p2_data", noc2_data_out, mk_hdr(0, 900));
    check("t6_cnt1_after", pkt_cnt_p1, 1);
    check("t6_cnt2_after", pkt_cnt_p2, 1);
    pipe2_val = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
